fde_sequencer: RTL and testbench

//   Multi-cycle control FSM for the 5-bit-PC fetch/decode/execute datapath.
//   - Owns the PC and steps it through instruction memory.
//   - Decodes each opcode and drives the data-memory read/write strobes
//     (one strobe per instruction) and the data-memory address.
//   - Sits between the instruction-memory output and the data-memory

---
 rtl/fde_sequencer.sv | 137 +++++++++++++
 tb/tb_fde_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fde_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM. Owns the PC, decodes each
// opcode, issues one data-memory strobe per LOAD/STORE, waits MEM_LAT cycles
// for the memory, and counts retired instructions with saturation.
module fde_sequencer #(
  parameter int PC_W    = 5,
  parameter int OP_W    = 8,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op_code,
  output logic [PC_W-1:0]  pc,
  output logic             mem_read,
  output logic             mem_write,
  output logic             load_en,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // Wait counter only needs to hold MEM_LAT down to 1.
  localparam int WCNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(MEM_LAT);

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(2);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(3);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state_q,   state_d;
  logic [PC_W-1:0]   pc_q,      pc_d;
  logic [OP_W-1:0]   ir_q,      ir_d;
  logic [WCNT_W-1:0] wcnt_q,    wcnt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              retire;

  // Next-state and datapath update logic for the sequencer FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wcnt_d  = wcnt_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = op_code;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_q)
          OP_NOP: begin
            pc_d    = pc_q + PC_W'(1);
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_LOAD, OP_STORE: begin
            wcnt_d  = WCNT_INIT;
            state_d = S_EXEC;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          default: state_d = S_ERR;
        endcase
      end
      S_EXEC: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) begin
          pc_d    = pc_q + PC_W'(1);
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
    retired_d = (retire && (retired_q != '1)) ? retired_q + CNT_W'(1) : retired_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      wcnt_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wcnt_q    <= wcnt_d;
      retired_q <= retired_d;
    end
  end

  // Outputs decode only registered state, so they are stable for a full cycle.
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign mem_read  = (state_q == S_EXEC) && (ir_q == OP_LOAD);
  assign mem_write = (state_q == S_EXEC) && (ir_q == OP_STORE);
  assign load_en   = (state_q == S_WAIT) && (wcnt_q == WCNT_W'(1)) && (ir_q == OP_LOAD);
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
  assign halted    = (state_q == S_HALT);
  assign illegal   = (state_q == S_ERR);

endmodule

// File: tb/tb_fde_sequencer.sv
// Self-checking bench for fde_sequencer: directed programs in a small
// instruction memory, with a scoreboard of expected data-memory events.
module tb_fde_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] op_code;
  logic [4:0] pc;
  logic       mem_read, mem_write, load_en, busy, halted, illegal;
  logic [7:0] retired;

  logic       rst_s_n;
  logic       start_s;
  logic [7:0] op_code_s;
  logic [4:0] pc_s;
  logic       mem_read_s, mem_write_s, load_en_s, busy_s, halted_s, illegal_s;
  logic [1:0] retired_s;

  logic [7:0] imem [0:31];

  typedef struct packed {
    logic [1:0] kind;
    logic [4:0] pc;
  } ev_t;

  localparam logic [1:0] EV_READ  = 2'd0;
  localparam logic [1:0] EV_WRITE = 2'd1;
  localparam logic [1:0] EV_LOAD  = 2'd2;
  localparam logic [1:0] EV_NONE  = 2'd3;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  fde_sequencer dut (
    .CLK(clk), .reset_n(reset_n), .start(start), .op_code(op_code),
    .pc(pc), .mem_read(mem_read), .mem_write(mem_write), .load_en(load_en),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  fde_sequencer #(.CNT_W(2)) dut_sat (
    .CLK(clk), .reset_n(rst_s_n), .start(start_s), .op_code(op_code_s),
    .pc(pc_s), .mem_read(mem_read_s), .mem_write(mem_write_s), .load_en(load_en_s),
    .busy(busy_s), .halted(halted_s), .illegal(illegal_s), .retired(retired_s)
  );

  assign op_code = imem[pc];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = 8'h00;
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [4:0] addr);
    ev_t e;
    e.kind = kind;
    e.pc   = addr;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every strobe / load_en must match the next expected event.
  always @(negedge clk) begin
    ev_t got_ev;
    ev_t exp_ev;
    if (mem_read || mem_write || load_en) begin
      check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
      got_ev.kind = mem_read ? EV_READ : (mem_write ? EV_WRITE : EV_LOAD);
      got_ev.pc   = pc;
      if (sb.size() == 0) begin
        exp_ev.kind = EV_NONE;
        exp_ev.pc   = 5'd0;
        check("sb_unexpected", 32'(got_ev), 32'(exp_ev));
      end else begin
        exp_ev = sb.pop_front();
        check("sb_event", 32'(got_ev), 32'(exp_ev));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    rst_s_n   = 1'b0;
    start_s   = 1'b0;
    op_code_s = 8'h00;
    clear_imem();

    // Reset state.
    do_reset();
    check("rst0_flags", 32'({mem_read, mem_write, load_en, busy, halted, illegal}), 32'd0);
    check("rst0_pc", 32'(pc), 32'd0);
    check("rst0_retired", 32'(retired), 32'd0);

    // Reset asserted while a STORE strobe is in flight.
    imem[0] = 8'd2;
    push_ev(EV_WRITE, 5'd0);
    start_pulse();
    for (int i = 0; i < 10 && !mem_write; i++) tick();
    check("rst_store_seen", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    tick();
    check("rst_mid_write", 32'(mem_write), 32'd0);
    check("rst_mid_pc", 32'(pc), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_retired", 32'(retired), 32'd0);
    check("rst_mid_drained", 32'(sb.size()), 32'd0);

    // NOP stream with PC wrap.
    clear_imem();
    do_reset();
    start_pulse();
    check("nop_busy", 32'(busy), 32'd1);
    repeat (2) tick();
    check("nop_pc_t2", 32'(pc), 32'd1);
    repeat (60) tick();
    check("nop_pc_t62", 32'(pc), 32'd31);
    check("nop_ret_t62", 32'(retired), 32'd31);
    repeat (2) tick();
    check("nop_pc_wrap", 32'(pc), 32'd0);
    check("nop_ret_wrap", 32'(retired), 32'd32);
    repeat (2) tick();
    check("nop_pc_after_wrap", 32'(pc), 32'd1);

    // LOAD with MEM_LAT=1.
    do_reset();
    imem[0] = 8'd1;
    push_ev(EV_READ, 5'd0);
    push_ev(EV_LOAD, 5'd0);
    start_pulse();
    repeat (2) tick();
    check("ld_read_t2", 32'(mem_read), 32'd1);
    tick();
    check("ld_read_t3", 32'(mem_read), 32'd0);
    check("ld_en_t3", 32'(load_en), 32'd1);
    tick();
    check("ld_pc_t4", 32'(pc), 32'd1);
    check("ld_ret_t4", 32'(retired), 32'd1);
    check("ld_en_t4", 32'(load_en), 32'd0);
    do_reset();
    check("ld_drained", 32'(sb.size()), 32'd0);

    // STORE then HALT, then restart from HALT.
    clear_imem();
    imem[0] = 8'd2;
    imem[1] = 8'd3;
    push_ev(EV_WRITE, 5'd0);
    start_pulse();
    repeat (6) tick();
    check("st_halted", 32'(halted), 32'd1);
    check("st_pc", 32'(pc), 32'd1);
    check("st_ret", 32'(retired), 32'd2);
    check("st_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("st_hold", 32'({halted, pc}), 32'({1'b1, 5'd1}));
    push_ev(EV_WRITE, 5'd0);
    start_pulse();
    check("re_pc", 32'(pc), 32'd0);
    check("re_halted", 32'(halted), 32'd0);
    check("re_busy", 32'(busy), 32'd1);
    repeat (6) tick();
    check("re_halted2", 32'(halted), 32'd1);
    check("re_ret", 32'(retired), 32'd4);
    check("st_drained", 32'(sb.size()), 32'd0);

    // Illegal opcode: sticky, ignores start, cleared only by reset.
    do_reset();
    clear_imem();
    imem[0] = 8'hFF;
    start_pulse();
    repeat (2) tick();
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);
    start_pulse();
    repeat (3) tick();
    start_pulse();
    repeat (3) tick();
    check("ill_sticky", 32'({illegal, busy, halted}), 32'({1'b1, 1'b0, 1'b0}));
    check("ill_pc", 32'(pc), 32'd0);
    check("ill_ret", 32'(retired), 32'd0);
    do_reset();
    check("ill_cleared", 32'(illegal), 32'd0);
    check("ill_drained", 32'(sb.size()), 32'd0);

    // Retired-counter saturation with a 2-bit counter.
    rst_s_n = 1'b1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (4) tick();
    check("sat_ret_t4", 32'(retired_s), 32'd2);
    repeat (2) tick();
    check("sat_ret_t6", 32'(retired_s), 32'd3);
    repeat (4) tick();
    check("sat_ret_t10", 32'(retired_s), 32'd3);
    check("sat_pc_t10", 32'(pc_s), 32'd5);
    check("sat_flags", 32'({mem_read_s, mem_write_s, load_en_s, busy_s, halted_s, illegal_s}),
          32'(6'b000100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
